whack_btn_encoder: RTL and testbench

Input-side front end for the whack-a-mole game. The game core drives mole LEDs and reads buttons; this block returns the buttons to it as clean, debounced press events.
- Synchronises and debounces the 9 breadboard push buttons.
- Detects press edges and encodes each press as a button index.
- Queues the events in a small FIFO, popped by the scoring logic through a valid/ready handshake.

---
 rtl/whack_pkg.sv | 29 ++
 rtl/whack_btn_debounce.sv | 76 +++++++
 rtl/whack_btn_encoder.sv | 187 ++++++++++++++++++
 tb/tb_whack_btn_encoder.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/whack_pkg.sv
// ============================================================================
// Module   : whack_pkg
// Purpose  : Shared defaults, event-kind constants and the event record layout
//            for the whack-a-mole button front end.
// Options  : WHACK_RELEASE_EVT_EN (see whack_btn_encoder)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package whack_pkg;

    localparam int N_BTN      = 9;
    localparam int IDX_W      = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int DEB_CYCLES = 100000;

    // Event kinds carried next to the button index.
    localparam logic EVT_PRESS   = 1'b0;
    localparam logic EVT_RELEASE = 1'b1;

    // Event record as seen by the consumer: {kind, idx}.
    typedef struct packed {
        logic             kind;
        logic [IDX_W-1:0] idx;
    } evt_t;

endpackage : whack_pkg

`default_nettype wire

// File: rtl/whack_btn_debounce.sv
// ============================================================================
// Module   : whack_btn_debounce
// Purpose  : One button: 2-flop synchroniser, polarity normalisation and a
//            stable-count debouncer. Exposes both the registered level and the
//            value it takes at the next edge, so the parent can register edge
//            events in the same cycle the level changes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module whack_btn_debounce #(
    parameter int DEB_CYCLES     = 100000,
    parameter int BTN_ACTIVE_LOW = 1
) (
    input  logic cin,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic level_nxt
);

    localparam int              CNT_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    // Raw level of a released button; the synchroniser resets to it so that
    // a button held through reset re-qualifies like a fresh press.
    localparam logic            IDLE_RAW = (BTN_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic             sync_q1;
    logic             sync_q2;
    logic             pressed;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // Two-flop synchroniser for the asynchronous raw input.
    always_ff @(posedge cin) begin
        if (rst) begin
            sync_q1 <= IDLE_RAW;
            sync_q2 <= IDLE_RAW;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
        end
    end

    // 1 = pressed, independent of board wiring.
    assign pressed = sync_q2 ^ IDLE_RAW;

    // Count consecutive cycles of disagreement; flip the level once the count
    // has reached its last value while the input still disagrees.
    always_comb begin
        cnt_nxt   = cnt;
        level_nxt = level;
        if (pressed == level) begin
            cnt_nxt = '0;
        end else if (cnt == CNT_LAST) begin
            level_nxt = pressed;
            cnt_nxt   = '0;
        end else begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    // Debounced level and stability counter.
    always_ff @(posedge cin) begin
        if (rst) begin
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            level <= level_nxt;
            cnt   <= cnt_nxt;
        end
    end

endmodule : whack_btn_debounce

`default_nettype wire

// File: rtl/whack_btn_encoder.sv
// ============================================================================
// Module   : whack_btn_encoder
// Purpose  : Debounces the push buttons, turns press edges into indexed
//            events (lowest index first, one per cycle) and queues them in a
//            small FIFO drained through a valid/ready handshake. Events that
//            find the FIFO full are dropped and counted.
// Options  : WHACK_RELEASE_EVT_EN - also report release edges (evt_kind=1),
//            served after all pending presses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module whack_btn_encoder #(
    parameter int N_BTN          = whack_pkg::N_BTN,
    parameter int IDX_W          = whack_pkg::IDX_W,
    parameter int DEB_CYCLES     = whack_pkg::DEB_CYCLES,
    parameter int FIFO_DEPTH     = whack_pkg::FIFO_DEPTH,
    parameter int BTN_ACTIVE_LOW = 1
) (
    input  logic             cin,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic             evt_valid,
    output logic [IDX_W-1:0] evt_idx,
    output logic             evt_kind,
    input  logic             evt_ready,
    output logic             drop_pulse,
    output logic [7:0]       drop_cnt
);

    import whack_pkg::*;

    // One extra pointer bit distinguishes full from empty.
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PTR_W = AW + 1;

    logic [N_BTN-1:0] level_nxt;
    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] pending;
    logic [N_BTN-1:0] press_sel;

    logic             push;
    logic [IDX_W-1:0] push_idx;
    logic             push_kind;

    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             wr_en;
    logic             drop;
    logic [IDX_W-1:0] mem_idx [FIFO_DEPTH];

    // Per-button synchroniser and debouncer.
    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        whack_btn_debounce #(
            .DEB_CYCLES     (DEB_CYCLES),
            .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
        ) u_deb (
            .cin       (cin),
            .rst       (rst),
            .raw       (btn_raw[g]),
            .level     (btn_level[g]),
            .level_nxt (level_nxt[g])
        );
    end

    // A rising debounced level is known one cycle early via level_nxt, so the
    // pending bit lands on the same edge as the level itself.
    assign rise      = level_nxt & ~btn_level;
    // Isolate the lowest set pending bit.
    assign press_sel = pending & (~pending + N_BTN'(1));

`ifdef WHACK_RELEASE_EVT_EN
    logic [N_BTN-1:0] fall;
    logic [N_BTN-1:0] rel_pending;
    logic [N_BTN-1:0] rel_sel;
    logic [N_BTN-1:0] rel_clr;
    logic             mem_kind [FIFO_DEPTH];

    assign fall    = ~level_nxt & btn_level;
    assign rel_sel = rel_pending & (~rel_pending + N_BTN'(1));
    // Releases are only served once no press is waiting.
    assign rel_clr = (pending == '0) ? rel_sel : '0;

    // Release pending mask: set on debounced falling edge, cleared when served.
    always_ff @(posedge cin) begin
        if (rst) begin
            rel_pending <= '0;
        end else begin
            rel_pending <= (rel_pending & ~rel_clr) | fall;
        end
    end
`endif

    // Arbiter: pick the lowest pending press, else (optionally) the lowest
    // pending release.
    always_comb begin
        push      = 1'b0;
        push_idx  = '0;
        push_kind = EVT_PRESS;
        if (pending != '0) begin
            push = 1'b1;
            for (int i = 0; i < N_BTN; i++) begin
                if (press_sel[i]) begin
                    push_idx = IDX_W'(i);
                end
            end
        end
`ifdef WHACK_RELEASE_EVT_EN
        else if (rel_pending != '0) begin
            push      = 1'b1;
            push_kind = EVT_RELEASE;
            for (int i = 0; i < N_BTN; i++) begin
                if (rel_sel[i]) begin
                    push_idx = IDX_W'(i);
                end
            end
        end
`endif
    end

    // Press pending mask: the served bit always clears, even if the event is
    // then dropped; a new edge on an already pending bit simply merges.
    always_ff @(posedge cin) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~press_sel) | rise;
        end
    end

    assign fifo_empty = (wptr == rptr);
    assign fifo_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop        = !fifo_empty && evt_ready;
    // A pop frees the head slot in the same cycle, so a push into a full
    // FIFO still succeeds when paired with a pop.
    assign wr_en      = push && (!fifo_full || pop);
    assign drop       = push && fifo_full && !pop;

    // FIFO storage, pointers and drop accounting.
    always_ff @(posedge cin) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            drop_pulse <= 1'b0;
            drop_cnt   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_idx[i] <= '0;
`ifdef WHACK_RELEASE_EVT_EN
                mem_kind[i] <= EVT_PRESS;
`endif
            end
        end else begin
            if (wr_en) begin
                mem_idx[wptr[AW-1:0]] <= push_idx;
`ifdef WHACK_RELEASE_EVT_EN
                mem_kind[wptr[AW-1:0]] <= push_kind;
`endif
                wptr <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            drop_pulse <= drop;
            if (drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    assign evt_valid = !fifo_empty;
    assign evt_idx   = mem_idx[rptr[AW-1:0]];
`ifdef WHACK_RELEASE_EVT_EN
    assign evt_kind  = mem_kind[rptr[AW-1:0]];
`else
    // Without release tracking every event is a press.
    assign evt_kind  = EVT_PRESS;
    logic unused_kind;
    assign unused_kind = push_kind;
`endif

endmodule : whack_btn_encoder

`default_nettype wire

// File: tb/tb_whack_btn_encoder.sv
`default_nettype none

module tb_whack_btn_encoder;

    import whack_pkg::*;

    localparam int TB_N   = 9;
    localparam int TB_DEB = 4;

    logic            cin = 1'b0;
    logic            rst;
    logic [TB_N-1:0] btn_raw;
    logic [TB_N-1:0] btn_level;
    logic            evt_valid;
    logic [3:0]      evt_idx;
    logic            evt_kind;
    logic            evt_ready;
    logic            drop_pulse;
    logic [7:0]      drop_cnt;

    int   checks     = 0;
    int   errors     = 0;
    int   drops_seen = 0;
    int   drop_total = 0;
    evt_t exp_q[$];
    evt_t mon_e;

    whack_btn_encoder #(
        .N_BTN          (TB_N),
        .IDX_W          (4),
        .DEB_CYCLES     (TB_DEB),
        .FIFO_DEPTH     (4),
        .BTN_ACTIVE_LOW (1)
    ) dut (
        .cin        (cin),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .evt_valid  (evt_valid),
        .evt_idx    (evt_idx),
        .evt_kind   (evt_kind),
        .evt_ready  (evt_ready),
        .drop_pulse (drop_pulse),
        .drop_cnt   (drop_cnt)
    );

    always #5 cin = ~cin;

    function automatic evt_t mk_evt(input logic kind, input int idx);
        evt_t e;
        e.kind = kind;
        e.idx  = 4'(idx);
        return e;
    endfunction

    // Scoreboard consumer: every accepted event must match the queue head.
    always @(negedge cin) begin
        if (!rst && evt_valid && evt_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got idx=%0d kind=%0d, required no event", evt_idx, evt_kind);
            end else begin
                mon_e = exp_q.pop_front();
                if (evt_idx !== mon_e.idx || evt_kind !== mon_e.kind) begin
                    errors++;
                    $display("FAIL event_order: got idx=%0d kind=%0d, required idx=%0d kind=%0d",
                             evt_idx, evt_kind, mon_e.idx, mon_e.kind);
                end
            end
        end
        if (!rst && drop_pulse) drops_seen++;
    end

    // Advance to just after the next active edge.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge cin);
            #1;
        end
    endtask

    task automatic press_btns(input logic [TB_N-1:0] mask, input bit expect_evt);
        btn_raw = btn_raw & ~mask;
        if (expect_evt) begin
            for (int i = 0; i < TB_N; i++) begin
                if (mask[i]) exp_q.push_back(mk_evt(EVT_PRESS, i));
            end
        end
    endtask

    task automatic release_btns(input logic [TB_N-1:0] mask);
        btn_raw = btn_raw | mask;
`ifdef WHACK_RELEASE_EVT_EN
        for (int i = 0; i < TB_N; i++) begin
            if (mask[i]) exp_q.push_back(mk_evt(EVT_RELEASE, i));
        end
`endif
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d expected events still outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(3);
        checks++;
        if (btn_level !== '0 || evt_valid !== 1'b0 || evt_idx !== 4'd0 || evt_kind !== 1'b0 ||
            drop_pulse !== 1'b0 || drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_values: got level=%h valid=%b idx=%0d kind=%b dp=%b dc=%0d, required all 0",
                     btn_level, evt_valid, evt_idx, evt_kind, drop_pulse, drop_cnt);
        end
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_debounce();
        int d0 = drops_seen;
        evt_ready = 1'b1;
        press_btns(9'h020, 1'b1);
        step(5);
        checks++;
        if (btn_level[5] !== 1'b0) begin
            errors++;
            $display("FAIL deb_early: got level[5]=%b at cycle 5, required 0", btn_level[5]);
        end
        step();
        checks++;
        if (btn_level[5] !== 1'b1) begin
            errors++;
            $display("FAIL deb_rise: got level[5]=%b at cycle 6, required 1", btn_level[5]);
        end
        step(4);
        wait_drain("debounce", 10);
        release_btns(9'h020);
        step(10);
        wait_drain("debounce_rel", 10);
        checks++;
        if (drop_cnt !== 8'd0 || drops_seen != d0) begin
            errors++;
            $display("FAIL deb_nodrop: got drop_cnt=%0d pulses=%0d, required 0 0", drop_cnt, drops_seen - d0);
        end
    endtask

    task automatic test_glitch();
        bit seen = 1'b0;
        press_btns(9'h004, 1'b0);
        step(3);
        btn_raw[2] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (btn_level[2]) seen = 1'b1;
        end
        checks++;
        if (seen || btn_level[2] !== 1'b0) begin
            errors++;
            $display("FAIL glitch_level: got level[2] high=%b, required 0", seen);
        end
    endtask

    task automatic test_simultaneous();
        int order[3] = '{0, 3, 7};
        int n = 0;
        evt_ready = 1'b1;
        press_btns(9'h089, 1'b1);
        while (!evt_valid && n < 20) begin
            step();
            n++;
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (evt_valid !== 1'b1 || evt_idx !== 4'(order[k])) begin
                errors++;
                $display("FAIL simul_seq%0d: got valid=%b idx=%0d, required valid=1 idx=%0d",
                         k, evt_valid, evt_idx, order[k]);
            end
            step();
        end
        wait_drain("simul", 10);
        release_btns(9'h089);
        step(10);
        wait_drain("simul_rel", 10);
    endtask

    task automatic test_full_fifo();
        int d0 = drops_seen;
        evt_ready = 1'b0;
        press_btns(9'h07E, 1'b0);
        for (int i = 1; i <= 4; i++) exp_q.push_back(mk_evt(EVT_PRESS, i));
        step(16);
        drop_total = drop_total + 2;
        checks++;
        if (evt_valid !== 1'b1 || evt_idx !== 4'd1) begin
            errors++;
            $display("FAIL full_head: got valid=%b idx=%0d, required valid=1 idx=1", evt_valid, evt_idx);
        end
        checks++;
        if (drops_seen - d0 != 2) begin
            errors++;
            $display("FAIL full_pulses: got %0d drop pulses, required 2", drops_seen - d0);
        end
        checks++;
        if (drop_cnt !== 8'(drop_total)) begin
            errors++;
            $display("FAIL full_dropcnt: got %0d, required %0d", drop_cnt, drop_total);
        end
        evt_ready = 1'b1;
        step(4);
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_empty: got valid=%b after 4 pops, required 0", evt_valid);
        end
        wait_drain("full", 4);
        release_btns(9'h07E);
        step(10);
        wait_drain("full_rel", 12);
    endtask

    task automatic test_reset_mid();
        int n = 0;
        evt_ready = 1'b0;
        press_btns(9'h00E, 1'b0);
        step(10);
        checks++;
        if (evt_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_queued: got valid=%b before reset, required 1", evt_valid);
        end
        press_btns(9'h100, 1'b0);
        step(2);
        rst = 1'b1;
        step();
        checks++;
        if (evt_valid !== 1'b0 || btn_level !== '0 || drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset: got valid=%b level=%h dc=%0d, required 0 0 0", evt_valid, btn_level, drop_cnt);
        end
        btn_raw[3:1] = 3'b111;
        step(2);
        exp_q.delete();
        drop_total = 0;
        rst = 1'b0;
        evt_ready = 1'b1;
        exp_q.push_back(mk_evt(EVT_PRESS, 8));
        while (!btn_level[8] && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (n != 2 + TB_DEB) begin
            errors++;
            $display("FAIL mid_requal: got level[8] after %0d cycles, required %0d", n, 2 + TB_DEB);
        end
        wait_drain("mid", 10);
        release_btns(9'h100);
        step(10);
        wait_drain("mid_rel", 10);
    endtask

`ifdef WHACK_RELEASE_EVT_EN
    task automatic test_release_evt();
        evt_ready = 1'b1;
        press_btns(9'h010, 1'b1);
        step(12);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rel_press: got %0d outstanding, required 0", exp_q.size());
        end
        release_btns(9'h010);
        step(12);
        wait_drain("release", 10);
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        btn_raw   = '1;
        evt_ready = 1'b0;
        rst       = 1'b1;
        test_reset();
        test_debounce();
        test_glitch();
        test_simultaneous();
        test_full_fifo();
        test_reset_mid();
`ifdef WHACK_RELEASE_EVT_EN
        test_release_evt();
`endif
        step(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_whack_btn_encoder

`default_nettype wire
